d_cache_controller: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache between the CPU data port and the SDRAM arbiter.
- Produces d_cache_read_miss and d_cache_write_miss, which the hazard logic ORs into the pipeline stall.
- The CPU holds its read/write request stable while the corresponding miss output is high.
- Read and write paths are independent ports because they come from different pipeline stages.

---
 rtl/d_cache_controller.sv | 223 ++++++++++++++++++++++
 tb/tb_d_cache_controller.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_cache_controller.sv
// d_cache_controller
// Direct-mapped, write-through, no-write-allocate data cache sitting between
// the CPU data port and the SDRAM arbiter. A single-entry write buffer drains
// writes to memory; read misses fetch a whole line as a burst.
// Optional feature: define D_CACHE_STATS_EN to add saturating hit/miss counters.
module d_cache_controller #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int INDEX_BITS  = 4,
  parameter int OFFSET_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_ren,
  input  logic [ADDR_WIDTH-1:0] data_raddr,
  output logic [DATA_WIDTH-1:0] data_rdata,
  input  logic                  data_wren,
  input  logic [ADDR_WIDTH-1:0] data_waddr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  d_cache_read_miss,
  output logic                  d_cache_write_miss,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid
`ifdef D_CACHE_STATS_EN
  ,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
`endif
);

  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << OFFSET_BITS;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FILL_REQ  = 2'd1,
    ST_FILL_WAIT = 2'd2
  } state_t;

  state_t                  state_r;
  logic [TAG_BITS-1:0]     tag_r   [LINES];
  logic [DATA_WIDTH-1:0]   data_r  [LINES][WORDS];
  logic [LINES-1:0]        valid_r;

  logic                    wbuf_full_r;
  logic [ADDR_WIDTH-1:0]   wbuf_addr_r;
  logic [DATA_WIDTH-1:0]   wbuf_data_r;

  logic [TAG_BITS-1:0]     fill_tag_r;
  logic [INDEX_BITS-1:0]   fill_idx_r;
  logic [OFFSET_BITS-1:0]  fill_cnt_r;

  logic [TAG_BITS-1:0]     rd_tag_s;
  logic [INDEX_BITS-1:0]   rd_idx_s;
  logic [OFFSET_BITS-1:0]  rd_off_s;
  logic [TAG_BITS-1:0]     wr_tag_s;
  logic [INDEX_BITS-1:0]   wr_idx_s;
  logic [OFFSET_BITS-1:0]  wr_off_s;

  logic                    idle_s;
  logic                    rd_hit_s;
  logic                    wr_hit_s;
  logic                    rd_done_s;
  logic                    wr_accept_s;
  logic                    drain_ack_s;
  logic                    fill_start_s;
  logic                    wr_conflict_s;
  logic                    fill_word_s;
  logic                    fill_last_s;

  // Address split: tag | index | offset
  assign rd_tag_s = data_raddr[ADDR_WIDTH-1 -: TAG_BITS];
  assign rd_idx_s = data_raddr[OFFSET_BITS +: INDEX_BITS];
  assign rd_off_s = data_raddr[OFFSET_BITS-1:0];
  assign wr_tag_s = data_waddr[ADDR_WIDTH-1 -: TAG_BITS];
  assign wr_idx_s = data_waddr[OFFSET_BITS +: INDEX_BITS];
  assign wr_off_s = data_waddr[OFFSET_BITS-1:0];

  assign idle_s   = (state_r == ST_IDLE);
  assign rd_hit_s = valid_r[rd_idx_s] & (tag_r[rd_idx_s] == rd_tag_s);
  assign wr_hit_s = valid_r[wr_idx_s] & (tag_r[wr_idx_s] == wr_tag_s);

  // In IDLE an outstanding request is always the buffer drain.
  assign drain_ack_s  = idle_s & wbuf_full_r & mem_req & mem_we & mem_ack;
  assign fill_start_s = idle_s & ~wbuf_full_r & data_ren & ~rd_hit_s;

  // A write into the line being (or about to be) refilled would leave the
  // fill result stale, so hold it off until the fill has completed. This
  // includes the cycle in which the fill is launched.
  assign wr_conflict_s = (~idle_s & (wr_idx_s == fill_idx_r)) |
                         (fill_start_s & (wr_idx_s == rd_idx_s));

  assign d_cache_read_miss  = data_ren & (~rd_hit_s | ~idle_s | wbuf_full_r);
  // The drain-ack cycle frees the buffer, so a waiting write is taken then.
  assign d_cache_write_miss = data_wren & ((wbuf_full_r & ~drain_ack_s) | wr_conflict_s);

  assign rd_done_s   = data_ren & ~d_cache_read_miss;
  assign wr_accept_s = data_wren & ~d_cache_write_miss;

  assign fill_word_s = (state_r == ST_FILL_WAIT) & mem_rvalid;
  assign fill_last_s = fill_word_s & (fill_cnt_r == {OFFSET_BITS{1'b1}});

  // Line storage: burst fill words, write-hit updates and tag install
  always_ff @(posedge clk) begin
    if (fill_word_s) begin
      data_r[fill_idx_r][fill_cnt_r] <= mem_rdata;
    end
    if (wr_accept_s && wr_hit_s) begin
      data_r[wr_idx_s][wr_off_s] <= data_wdata;
    end
    if (fill_last_s) begin
      tag_r[fill_idx_r] <= fill_tag_r;
    end
  end

  // Control FSM with write buffer, valid bits and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      valid_r     <= '0;
      wbuf_full_r <= 1'b0;
      wbuf_addr_r <= '0;
      wbuf_data_r <= '0;
      fill_tag_r  <= '0;
      fill_idx_r  <= '0;
      fill_cnt_r  <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      data_rdata  <= '0;
    end else begin
      if (rd_done_s) begin
        data_rdata <= data_r[rd_idx_s][rd_off_s];
      end

      if (wr_accept_s) begin
        wbuf_full_r <= 1'b1;
        wbuf_addr_r <= data_waddr;
        wbuf_data_r <= data_wdata;
      end else if (drain_ack_s) begin
        wbuf_full_r <= 1'b0;
      end

      case (state_r)
        ST_IDLE: begin
          if (drain_ack_s) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end else if (wbuf_full_r) begin
            if (!mem_req) begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= wbuf_addr_r;
              mem_wdata <= wbuf_data_r;
            end
          end else if (fill_start_s) begin
            state_r           <= ST_FILL_REQ;
            mem_req           <= 1'b1;
            mem_we            <= 1'b0;
            mem_addr          <= {rd_tag_s, rd_idx_s, {OFFSET_BITS{1'b0}}};
            fill_tag_r        <= rd_tag_s;
            fill_idx_r        <= rd_idx_s;
            // The old line is being overwritten word by word.
            valid_r[rd_idx_s] <= 1'b0;
          end
        end
        ST_FILL_REQ: begin
          if (mem_ack) begin
            mem_req    <= 1'b0;
            fill_cnt_r <= '0;
            state_r    <= ST_FILL_WAIT;
          end
        end
        ST_FILL_WAIT: begin
          if (fill_word_s) begin
            fill_cnt_r <= fill_cnt_r + OFFSET_BITS'(1);
            if (fill_last_s) begin
              valid_r[fill_idx_r] <= 1'b1;
              state_r             <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef D_CACHE_STATS_EN
  logic fill_done_r;

  // Saturating statistics: hits are reads served without a preceding fill
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count   <= 16'h0000;
      miss_count  <= 16'h0000;
      fill_done_r <= 1'b0;
    end else begin
      if (fill_start_s && (miss_count != 16'hFFFF)) begin
        miss_count <= miss_count + 16'h0001;
      end
      if (rd_done_s) begin
        if (!fill_done_r && (hit_count != 16'hFFFF)) begin
          hit_count <= hit_count + 16'h0001;
        end
        fill_done_r <= 1'b0;
      end else if (fill_last_s) begin
        fill_done_r <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_d_cache_controller.sv
// Self-checking bench for d_cache_controller: directed sequences, a vector
// table of hit/simultaneous accesses, and randomized traffic checked against
// an architectural memory model (every read returns the latest accepted write).
module tb_d_cache_controller;

  logic        clk;
  logic        rst;
  logic        data_ren;
  logic [15:0] data_raddr;
  logic [15:0] data_rdata;
  logic        data_wren;
  logic [15:0] data_waddr;
  logic [15:0] data_wdata;
  logic        d_cache_read_miss;
  logic        d_cache_write_miss;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;

  d_cache_controller dut (
    .clk(clk), .rst(rst),
    .data_ren(data_ren), .data_raddr(data_raddr), .data_rdata(data_rdata),
    .data_wren(data_wren), .data_waddr(data_waddr), .data_wdata(data_wdata),
    .d_cache_read_miss(d_cache_read_miss), .d_cache_write_miss(d_cache_write_miss),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // ---------------- memory model and responder ----------------
  typedef struct { logic we; logic [15:0] addr; logic [15:0] data; } req_t;
  req_t req_log[$];
  logic [15:0] mem_model [logic [15:0]];
  logic [15:0] arch [logic [15:0]];

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    return mem_model.exists(a) ? mem_model[a] : (a ^ 16'h5A3C);
  endfunction

  function automatic logic [15:0] arch_rd(input logic [15:0] a);
    return arch.exists(a) ? arch[a] : mem_rd(a);
  endfunction

  logic        auto_resp = 1'b1;
  logic        rand_timing = 1'b0;
  int          ack_delay = 0;
  int          last_rv_cyc = 0;
  logic        resp_ack = 1'b0, resp_rvalid = 1'b0;
  logic [15:0] resp_rdata = 16'h0;
  logic        man_ack = 1'b0, man_rvalid = 1'b0;
  logic [15:0] man_rdata = 16'h0;

  assign mem_ack    = resp_ack | man_ack;
  assign mem_rvalid = resp_rvalid | man_rvalid;
  assign mem_rdata  = resp_rvalid ? resp_rdata : man_rdata;

  initial begin
    req_t r;
    int   d;
    forever begin
      @(negedge clk);
      if (auto_resp && mem_req && !rst) begin
        r.we = mem_we; r.addr = mem_addr; r.data = mem_wdata;
        req_log.push_back(r);
        d = rand_timing ? int'($urandom_range(0, 3)) : ack_delay;
        for (int i = 0; i < d; i++) @(negedge clk);
        resp_ack = 1'b1;
        if (r.we) mem_model[r.addr] = r.data;
        @(negedge clk);
        resp_ack = 1'b0;
        if (!r.we) begin
          for (int k = 0; k < 4; k++) begin
            d = rand_timing ? int'($urandom_range(0, 2)) : 0;
            for (int i = 0; i < d; i++) @(negedge clk);
            resp_rvalid = 1'b1;
            resp_rdata  = mem_rd(r.addr + 16'(k));
            last_rv_cyc = cyc;
            @(negedge clk);
            resp_rvalid = 1'b0;
          end
        end
      end
    end
  end

  // Wait (bounded) until a held read stops missing; leaves time at negedge+1.
  task automatic wait_rd(input string nm, output int c_done);
    logic ok;
    ok = 1'b0;
    c_done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (!d_cache_read_miss) begin ok = 1'b1; c_done = cyc; break; end
    end
    chk({nm, "_timeout"}, 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic ren; logic [15:0] raddr;
    logic wren; logic [15:0] waddr; logic [15:0] wdata;
    logic exp_rmiss; logic exp_wmiss; logic chk_rd; logic [15:0] exp_rdata;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int   cdone, n;
    logic prev_rd, rd_pend, wr_pend;
    logic [15:0] prev_exp, a;
    int   rd_wait, max_wait;

    vecs[0] = '{1'b1, 16'h0120, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h00A0};
    vecs[1] = '{1'b1, 16'h0121, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h00A1};
    vecs[2] = '{1'b1, 16'h0123, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h00A3};
    vecs[3] = '{1'b1, 16'h0122, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h00A2};
    vecs[4] = '{1'b1, 16'h0122, 1'b1, 16'h0122, 16'h1234, 1'b0, 1'b0, 1'b1, 16'h00A2};
    vecs[5] = '{1'b1, 16'h0122, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};

    for (int k = 0; k < 4; k++) mem_model[16'h0120 + 16'(k)] = 16'h00A0 + 16'(k);

    rst = 1'b1; data_ren = 1'b0; data_raddr = 16'h0; data_wren = 1'b0;
    data_waddr = 16'h0; data_wdata = 16'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst_mem_req",   32'(mem_req), 32'd0);
    chk("rst_mem_we",    32'(mem_we), 32'd0);
    chk("rst_mem_addr",  32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_rdata",     32'(data_rdata), 32'd0);

    // T1: cold read miss, line fill, 2-cycle latency after last rvalid
    req_log.delete();
    data_ren = 1'b1; data_raddr = 16'h0123; #1;
    chk("t1_rmiss", 32'(d_cache_read_miss), 32'd1);
    wait_rd("t1", cdone);
    chk("t1_miss_drop_cyc", 32'(cdone - last_rv_cyc), 32'd1);
    chk("t1_nreq", 32'(req_log.size()), 32'd1);
    if (req_log.size() > 0) begin
      chk("t1_fill_addr", 32'(req_log[0].addr), 32'h0120);
      chk("t1_fill_we",   32'(req_log[0].we), 32'd0);
    end
    @(negedge clk);
    chk("t1_rdata", 32'(data_rdata), 32'h00A3);
    chk("t1_rdata_cyc", 32'(cyc - last_rv_cyc), 32'd2);

    // T2: vector table of hits and a simultaneous read/write
    req_log.delete();
    for (int i = 0; i < 6; i++) begin
      data_ren = vecs[i].ren; data_raddr = vecs[i].raddr;
      data_wren = vecs[i].wren; data_waddr = vecs[i].waddr; data_wdata = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d_rmiss", i), 32'(d_cache_read_miss), 32'(vecs[i].exp_rmiss));
      chk($sformatf("vec%0d_wmiss", i), 32'(d_cache_write_miss), 32'(vecs[i].exp_wmiss));
      @(negedge clk);
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), 32'(data_rdata), 32'(vecs[i].exp_rdata));
    end
    wait_rd("t2", cdone);
    @(negedge clk);
    chk("t2_rdata_new", 32'(data_rdata), 32'h1234);
    chk("t2_nreq", 32'(req_log.size()), 32'd1);
    if (req_log.size() > 0) chk("t2_req_we", 32'(req_log[0].we), 32'd1);

    // T3: write hit, drain, read returns new data
    req_log.delete();
    data_ren = 1'b0; data_wren = 1'b1; data_waddr = 16'h0121; data_wdata = 16'hBEEF; #1;
    chk("t3_wmiss", 32'(d_cache_write_miss), 32'd0);
    @(negedge clk);
    data_wren = 1'b0; data_ren = 1'b1; data_raddr = 16'h0121;
    wait_rd("t3", cdone);
    @(negedge clk);
    chk("t3_rdata", 32'(data_rdata), 32'hBEEF);
    chk("t3_nreq", 32'(req_log.size()), 32'd1);
    if (req_log.size() > 0) begin
      chk("t3_req", {15'd0, req_log[0].we, req_log[0].addr}, {15'd0, 1'b1, 16'h0121});
      chk("t3_req_data", 32'(req_log[0].data), 32'hBEEF);
    end

    // T4: two writes, drain ack delayed 5 cycles
    req_log.delete();
    ack_delay = 5;
    data_ren = 1'b0; data_wren = 1'b1; data_waddr = 16'h0130; data_wdata = 16'h1111; #1;
    chk("t4_w1_wmiss", 32'(d_cache_write_miss), 32'd0);
    @(negedge clk);
    data_waddr = 16'h0131; data_wdata = 16'h2222; #1;
    chk("t4_w2_wmiss", 32'(d_cache_write_miss), 32'd1);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (!d_cache_write_miss) break;
      @(negedge clk); #1;
      n++;
    end
    chk("t4_wait_ge5", 32'(n >= 5), 32'd1);
    chk("t4_accept_on_ack", 32'(mem_ack & ~d_cache_write_miss), 32'd1);
    @(negedge clk);
    data_wren = 1'b0;
    repeat (20) @(negedge clk);
    chk("t4_nreq", 32'(req_log.size()), 32'd2);
    if (req_log.size() == 2) begin
      chk("t4_req0", {req_log[0].addr, req_log[0].data}, {16'h0130, 16'h1111});
      chk("t4_req1", {req_log[1].addr, req_log[1].data}, {16'h0131, 16'h2222});
    end
    ack_delay = 0;

    // T5: read miss while buffer holds a write to the same address
    req_log.delete();
    data_wren = 1'b1; data_waddr = 16'h0200; data_wdata = 16'h7777; #1;
    chk("t5_wmiss", 32'(d_cache_write_miss), 32'd0);
    @(negedge clk);
    data_wren = 1'b0; data_ren = 1'b1; data_raddr = 16'h0200; #1;
    chk("t5_rmiss", 32'(d_cache_read_miss), 32'd1);
    wait_rd("t5", cdone);
    @(negedge clk);
    chk("t5_rdata", 32'(data_rdata), 32'h7777);
    chk("t5_nreq", 32'(req_log.size()), 32'd2);
    if (req_log.size() == 2) begin
      chk("t5_first_drain", {15'd0, req_log[0].we, req_log[0].addr}, {15'd0, 1'b1, 16'h0200});
      chk("t5_then_fill",   {15'd0, req_log[1].we, req_log[1].addr}, {15'd0, 1'b0, 16'h0200});
    end
    data_ren = 1'b0;

    // Randomized traffic against the architectural model
    rand_timing = 1'b1;
    prev_rd = 1'b0; rd_pend = 1'b0; wr_pend = 1'b0; prev_exp = 16'h0;
    rd_wait = 0; max_wait = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (prev_rd) chk("rnd_rdata", 32'(data_rdata), 32'(prev_exp));
      if (!rd_pend) begin
        data_ren = ($urandom_range(0, 2) != 0);
        a = 16'($urandom_range(0, 127));
        if ($urandom_range(0, 3) == 0) a = a | 16'h1000;
        data_raddr = a;
      end
      if (!wr_pend) begin
        data_wren = ($urandom_range(0, 3) == 0);
        a = 16'($urandom_range(0, 127));
        if ($urandom_range(0, 3) == 0) a = a | 16'h1000;
        data_waddr = a;
        data_wdata = 16'($urandom);
      end
      #1;
      prev_rd = data_ren && !d_cache_read_miss;
      if (prev_rd) prev_exp = arch_rd(data_raddr);
      rd_pend = data_ren && d_cache_read_miss;
      wr_pend = data_wren && d_cache_write_miss;
      if (data_wren && !d_cache_write_miss) arch[data_waddr] = data_wdata;
      rd_wait = rd_pend ? rd_wait + 1 : 0;
      if (rd_wait > max_wait) max_wait = rd_wait;
    end
    @(negedge clk);
    if (prev_rd) chk("rnd_rdata", 32'(data_rdata), 32'(prev_exp));
    chk("rnd_no_starvation", 32'(max_wait < 200), 32'd1);
    data_ren = 1'b0; data_wren = 1'b0;
    rand_timing = 1'b0;
    repeat (40) @(negedge clk);

    // T6: reset in the middle of a fill
    auto_resp = 1'b0;
    @(negedge clk);
    data_ren = 1'b1; data_raddr = 16'h0300; #1;
    chk("t6_rmiss", 32'(d_cache_read_miss), 32'd1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) begin n = 1; break; end
    end
    chk("t6_req_seen", 32'(n), 32'd1);
    chk("t6_req_fill", {15'd0, mem_we, mem_addr}, {15'd0, 1'b0, 16'h0300});
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0; man_rvalid = 1'b1; man_rdata = 16'hDEAD;
    @(negedge clk);
    man_rdata = 16'hBEEF;
    @(negedge clk);
    man_rvalid = 1'b0;
    rst = 1'b1; data_ren = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_mem_req", 32'(mem_req), 32'd0);
    chk("t6_rst_rdata", 32'(data_rdata), 32'd0);
    man_rvalid = 1'b1; man_ack = 1'b1; man_rdata = 16'hFFFF;
    @(negedge clk);
    man_rvalid = 1'b0; man_ack = 1'b0;
    chk("t6_late_ignored", 32'(mem_req), 32'd0);
    data_ren = 1'b1; data_raddr = 16'h0120; #1;
    chk("t6_old_line_invalid", 32'(d_cache_read_miss), 32'd1);
    data_raddr = 16'h0300; #1;
    chk("t6_line_invalid", 32'(d_cache_read_miss), 32'd1);
    req_log.delete();
    auto_resp = 1'b1;
    wait_rd("t6", cdone);
    @(negedge clk);
    chk("t6_refill_rdata", 32'(data_rdata), 32'(mem_rd(16'h0300)));
    chk("t6_nreq", 32'(req_log.size()), 32'd1);
    if (req_log.size() > 0) chk("t6_refill_addr", 32'(req_log[0].addr), 32'h0300);
    data_ren = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
